// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: PC, instruction-memory and decode signals of the fetch unit.
//   master : fetch-unit side (drives pc_enable, mem_req_*, instr_valid/data/addr)
//   slave  : environment side (drives pc_in, flush, mem_req_ready, mem_rsp_*, instr_ready)
interface instr_fetch_unit_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] pc_in;
    logic          pc_enable;
    logic          flush;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_addr;

    modport master (
        input  pc_in, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
        output pc_enable, mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_addr
    );

    modport slave (
        output pc_in, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
        input  pc_enable, mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_addr
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues instruction reads at the current PC, buffers returned words in
// a DEPTH-entry in-order queue and hands them to decode over valid/ready.
//   clk      : clock, all state on posedge
//   reset_n  : synchronous reset, active low
//   bus      : instr_fetch_unit_if.master
//              pc_in/pc_enable           PC register read and advance
//              flush                     redirect, discard queued and in-flight words
//              mem_req_valid/ready/addr  read request
//              mem_rsp_valid/data        in-order read data
//              instr_valid/ready/data/addr  head instruction to decode
// Optional feature: define IFU_BYPASS_EN to forward a response straight to decode when the
// queue holds no filled word.
module instr_fetch_unit #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset_n,
    instr_fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    hd, tl, fp;
    logic [CW-1:0]    cnt, ufc, drop;
    logic             room, acc, head_ok, rsp_fill, byp, pop;

    always_comb begin
        // Words still owed by memory for flushed requests reserve slots too.
        room     = ({1'b0, cnt} + {1'b0, drop}) < (CW+1)'(DEPTH);
        acc      = reset_n && !bus.flush && room && bus.mem_req_ready;
        head_ok  = cnt != '0 && filled_q[hd];
        rsp_fill = bus.mem_rsp_valid && drop == '0 && ufc != '0;
`ifdef IFU_BYPASS_EN
        // Filled entries are contiguous from head, so an unfilled head means none are filled.
        byp      = rsp_fill && !head_ok && !bus.flush;
`else
        byp      = 1'b0;
`endif
        bus.instr_valid   = head_ok || byp;
        bus.instr_data    = byp ? bus.mem_rsp_data : data_q[hd];
        bus.instr_addr    = addr_q[hd];
        pop               = bus.instr_valid && bus.instr_ready;
        bus.mem_req_valid = reset_n && !bus.flush && room;
        bus.mem_req_addr  = reset_n ? bus.pc_in : '0;
        bus.pc_enable     = acc;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hd       <= '0;
            tl       <= '0;
            fp       <= '0;
            cnt      <= '0;
            ufc      <= '0;
            drop     <= '0;
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (bus.flush) begin
            hd   <= '0;
            tl   <= '0;
            fp   <= '0;
            cnt  <= '0;
            ufc  <= '0;
            // Every outstanding request becomes a drop; a response this cycle consumes one.
            drop <= drop + ufc - CW'(bus.mem_rsp_valid && (drop != '0 || ufc != '0));
        end else begin
            if (acc) begin
                addr_q[tl]   <= bus.pc_in;
                filled_q[tl] <= 1'b0;
                tl           <= tl + 1'b1;
            end
            if (rsp_fill && !(byp && pop)) begin
                data_q[fp]   <= bus.mem_rsp_data;
                filled_q[fp] <= 1'b1;
            end
            if (rsp_fill)
                fp <= fp + 1'b1;
            if (pop)
                hd <= hd + 1'b1;
            cnt  <= cnt + CW'(acc) - CW'(pop);
            ufc  <= ufc + CW'(acc) - CW'(rsp_fill);
            drop <= drop - CW'(bus.mem_rsp_valid && drop != '0);
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a PC and memory model.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.AW(16), .DW(16)) bus();
    instr_fetch_unit #(.AW(16), .DW(16), .DEPTH(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [15:0] a;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [15:0] exp_q[$];
    int          total = 0, bad = 0, cycle = 0, lat = 1, n_acc = 0, a0;
    logic [15:0] pc = '0, newpc = '0, watch_addr = '0, p0, b0;
    logic        watch = 1'b0, track_old = 1'b0, seen_old = 1'b0;
    logic        s_rv, s_pe, s_iv, s_pop;
    logic [15:0] s_addr, s_ia, s_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic cyc();
        logic [15:0] e;
        logic        acc;
        @(negedge clk);
        bus.pc_in = pc;
        if (pend.size() != 0 && pend[0].due <= cycle) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = pend[0].a ^ 16'hA5A5;
            void'(pend.pop_front());
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
        end
        #1;
        s_rv   = bus.mem_req_valid;
        s_pe   = bus.pc_enable;
        s_addr = bus.mem_req_addr;
        s_iv   = bus.instr_valid;
        s_ia   = bus.instr_addr;
        s_id   = bus.instr_data;
        s_pop  = s_iv && bus.instr_ready;
        acc    = s_rv && bus.mem_req_ready;
        if (s_rv)
            chk("req_addr", s_addr, pc);
        chk("pc_enable", s_pe, acc);
        if (bus.flush)
            chk("flush_req", s_rv, 0);
        if (s_pop) begin
            chk("sb_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("instr_addr", s_ia, e);
                chk("instr_data", s_id, e ^ 16'hA5A5);
            end
            if (watch) begin
                chk("first_after_flush", s_ia, watch_addr);
                watch = 1'b0;
            end
            if (track_old && s_ia < 16'd3)
                seen_old = 1'b1;
        end
        if (acc) begin
            pend.push_back('{pc, cycle + lat});
            exp_q.push_back(pc);
            n_acc++;
        end
        if (bus.flush) begin
            exp_q.delete();
            pc = newpc;
        end else if (acc)
            pc++;
        cycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.mem_req_ready = 1'b0;
        bus.instr_ready   = 1'b1;
        bus.flush         = 1'b0;
        for (int i = 0; i < 60 && (pend.size() != 0 || exp_q.size() != 0); i++)
            cyc();
        chk("drain", pend.size() + exp_q.size(), 0);
    endtask

    task automatic fill_up(input string tag);
        bus.instr_ready   = 1'b0;
        bus.mem_req_ready = 1'b1;
        lat = 1;
        a0  = n_acc;
        repeat (8) cyc();
        chk({tag, "_acc"}, n_acc - a0, 4);
        chk({tag, "_rv"}, s_rv, 0);
    endtask

    initial begin
        bus.pc_in         = '0;
        bus.flush         = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.instr_ready   = 1'b1;

        repeat (2) begin
            cyc();
            chk("rst_rv", s_rv, 0);
            chk("rst_pe", s_pe, 0);
            chk("rst_addr", s_addr, 0);
            chk("rst_iv", s_iv, 0);
            chk("rst_ia", s_ia, 0);
            chk("rst_id", s_id, 0);
        end
        reset_n = 1'b1;
        lat = 1;
        cyc();
        chk("rel_rv", s_rv, 1);
        chk("rel_addr", s_addr, 0);
        chk("rel_pe", s_pe, 1);

        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i >= 1)
                chk("stream_gap", s_pop, 1);
        end

        drain();
        fill_up("full");
        bus.instr_ready = 1'b1;
        cyc();
        chk("full_pop", s_pop, 1);
        chk("full_no_bypass", s_rv, 0);
        bus.instr_ready = 1'b0;
        cyc();
        chk("full_refill", s_rv, 1);
        cyc();
        chk("full_again", s_rv, 0);

        drain();
        bus.flush = 1'b1;
        newpc = 16'h0000;
        cyc();
        bus.flush = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.instr_ready = 1'b1;
        lat = 4;
        a0 = n_acc;
        repeat (3) cyc();
        chk("t4_inflight", n_acc - a0, 3);
        bus.flush = 1'b1;
        newpc = 16'h0100;
        cyc();
        chk("t4_flush_pe", s_pe, 0);
        bus.flush = 1'b0;
        watch = 1'b1;
        watch_addr = 16'h0100;
        track_old = 1'b1;
        seen_old = 1'b0;
        repeat (25) cyc();
        chk("t4_resumed", watch, 0);
        chk("t4_old_seen", seen_old, 0);
        track_old = 1'b0;

        drain();
        bus.instr_ready = 1'b0;
        bus.mem_req_ready = 1'b1;
        lat = 3;
        b0 = pc;
        repeat (4) cyc();
        bus.flush = 1'b1;
        bus.instr_ready = 1'b1;
        newpc = 16'h0200;
        cyc();
        chk("t5_pop", s_pop, 1);
        chk("t5_pop_addr", s_ia, b0);
        bus.flush = 1'b0;
        lat = 1;
        watch = 1'b1;
        watch_addr = 16'h0200;
        repeat (12) cyc();
        chk("t5_resumed", watch, 0);
        drain();
        fill_up("t5_drop_zero");

        drain();
        p0 = pc;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_rv", s_rv, 1);
            chk("bp_addr", s_addr, p0);
            chk("bp_pe", s_pe, 0);
        end
        bus.mem_req_ready = 1'b1;
        bus.instr_ready = 1'b1;
        lat = 1;
        cyc();
        bus.mem_req_ready = 1'b0;
        cyc();
`ifdef IFU_BYPASS_EN
        chk("bypass_same_cycle", s_iv, 1);
`else
        chk("rsp_not_same_cycle", s_iv, 0);
        cyc();
        chk("rsp_next_cycle", s_iv, 1);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
